// File: rtl/logicop_pkg.sv
// Shared types and constants for the logicop_pipe slice.
// Holds the operation encoding and the accepted-beat counter width.
package logicop_pkg;

  // Operation select encoding carried on the 3-bit op port.
  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } logicop_e;

  // Width of the accepted-beat counter and its saturation value.
  localparam int OP_COUNT_W = 16;
  localparam logic [OP_COUNT_W-1:0] OP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/logicop_core.sv
// Combinational bitwise operation selector feeding stage 0 of logicop_pipe.
module logicop_core
  import logicop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function of a and b named by op.
  always_comb begin
    y = '0;
    case (logicop_e'(op))
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSA: y = a;
      default:  y = a;
    endcase
  end

endmodule

// File: rtl/logicop_pipe.sv
// Valid/ready pipelined bitwise logic unit.
// The result is computed once at acceptance and carried through STAGES
// valid-tagged registers together with its zero flag.
// Optional feature macro: LOGICOP_PIPE_REDUCE_EN adds out_parity (^out) and
// out_ones (&out), pipelined alongside out.
module logicop_pipe
  import logicop_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [2:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  out_zero,
  output logic [OP_COUNT_W-1:0] op_count
`ifdef LOGICOP_PIPE_REDUCE_EN
  , output logic                out_parity
  , output logic                out_ones
`endif
);

`ifdef LOGICOP_PIPE_REDUCE_EN
  // Even/odd parity of a result word.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    parity_f = ^v;
  endfunction

  // All-ones detection of a result word.
  function automatic logic ones_f(input logic [WIDTH-1:0] v);
    ones_f = &v;
  endfunction
`endif

  logic [WIDTH-1:0]      core_y_s;
  logic                  accept_s;
  logic                  ready_chain_s;
  logic [STAGES-1:0]     load_s;
  logic [STAGES-1:0]     up_v_s;
  logic [WIDTH-1:0]      up_d_s [STAGES];
  logic [STAGES-1:0]     up_z_s;
  logic [STAGES-1:0]     stage_v_r;
  logic [WIDTH-1:0]      stage_d_r [STAGES];
  logic [STAGES-1:0]     stage_z_r;
  logic [OP_COUNT_W-1:0] op_count_r;
`ifdef LOGICOP_PIPE_REDUCE_EN
  logic [STAGES-1:0]     up_p_s;
  logic [STAGES-1:0]     up_o_s;
  logic [STAGES-1:0]     stage_p_r;
  logic [STAGES-1:0]     stage_o_r;
`endif

  logicop_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (core_y_s)
  );

  // Load enables: a stage loads when it, or any stage after it, has room,
  // or when the consumer is taking the last stage this cycle.
  always_comb begin
    ready_chain_s = out_ready;
    load_s        = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_chain_s = ready_chain_s | ~stage_v_r[i];
      load_s[i]     = ready_chain_s;
    end
  end

  assign in_ready = load_s[0] & ~rst;
  assign accept_s = in_valid & in_ready;

  // Upstream view of each stage: the core for stage 0, the previous stage otherwise.
  always_comb begin
    up_v_s    = '0;
    up_z_s    = '0;
    up_v_s[0] = in_valid;
    up_d_s[0] = core_y_s;
    up_z_s[0] = (core_y_s == '0);
`ifdef LOGICOP_PIPE_REDUCE_EN
    up_p_s    = '0;
    up_o_s    = '0;
    up_p_s[0] = parity_f(core_y_s);
    up_o_s[0] = ones_f(core_y_s);
`endif
    for (int i = 1; i < STAGES; i++) begin
      up_v_s[i] = stage_v_r[i-1];
      up_d_s[i] = stage_d_r[i-1];
      up_z_s[i] = stage_z_r[i-1];
`ifdef LOGICOP_PIPE_REDUCE_EN
      up_p_s[i] = stage_p_r[i-1];
      up_o_s[i] = stage_o_r[i-1];
`endif
    end
  end

  // Pipeline stages; payload only moves when a valid beat moves, so a
  // stalled or emptied stage keeps its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v_r <= '0;
      stage_z_r <= '0;
`ifdef LOGICOP_PIPE_REDUCE_EN
      stage_p_r <= '0;
      stage_o_r <= '0;
`endif
      for (int i = 0; i < STAGES; i++) begin
        stage_d_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load_s[i]) begin
          stage_v_r[i] <= up_v_s[i];
          if (up_v_s[i]) begin
            stage_d_r[i] <= up_d_s[i];
            stage_z_r[i] <= up_z_s[i];
`ifdef LOGICOP_PIPE_REDUCE_EN
            stage_p_r[i] <= up_p_s[i];
            stage_o_r[i] <= up_o_s[i];
`endif
          end
        end
      end
    end
  end

  // Accepted-beat counter, saturating at its maximum rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_r <= '0;
    end else if (accept_s && (op_count_r != OP_COUNT_MAX)) begin
      op_count_r <= op_count_r + 16'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign out_valid = stage_v_r[STAGES-1];
  assign out       = stage_d_r[STAGES-1];
  assign out_zero  = stage_z_r[STAGES-1];
  assign op_count  = op_count_r;
`ifdef LOGICOP_PIPE_REDUCE_EN
  assign out_parity = stage_p_r[STAGES-1];
  assign out_ones   = stage_o_r[STAGES-1];
`endif

endmodule

// File: tb/tb_logicop_pipe.sv
// Directed self-checking bench for logicop_pipe (WIDTH=8, STAGES=2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_logicop_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic        out_zero;
  logic [15:0] op_count;
`ifdef LOGICOP_PIPE_REDUCE_EN
  logic        out_parity;
  logic        out_ones;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logicop_pipe #(
    .WIDTH  (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .op_count  (op_count)
`ifdef LOGICOP_PIPE_REDUCE_EN
    , .out_parity (out_parity)
    , .out_ones   (out_ones)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp29 [8];

  initial begin
    exp29 = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; op = 3'd0;
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out", {56'd0, out}, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    chk("rst_op_count", {48'd0, op_count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // All eight ops back to back on F0/3C, latency 2
    a = 8'hF0; b = 8'h3C;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        op = 3'(c);
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("ops_out_valid", {63'd0, out_valid}, {63'd0, (c >= 1 && c <= 8)});
      if (c >= 1 && c <= 8) begin
        chk("ops_out", {56'd0, out}, {56'd0, exp29[c-1]});
        chk("ops_out_zero", {63'd0, out_zero}, 64'd0);
      end
    end
    chk("ops_count", {48'd0, op_count}, 64'd8);

    // Zero result
    a = 8'h0F; b = 8'hF0; op = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("zero_out_valid", {63'd0, out_valid}, 64'd1);
    chk("zero_out", {56'd0, out}, 64'd0);
    chk("zero_flag", {63'd0, out_zero}, 64'd1);
    step();
    chk("zero_drained", {63'd0, out_valid}, 64'd0);
    chk("zero_count", {48'd0, op_count}, 64'd9);

    // Backpressure: fill two stages, hold, then release
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'h11;
    #1;
    chk("bp_ready0", {63'd0, in_ready}, 64'd1);
    step();
    a = 8'h22;
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    step();
    a = 8'h33;
    #1;
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_full_out", {56'd0, out}, 64'h11);
    step();
    chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_out", {56'd0, out}, 64'h11);
    chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_passthru_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_rel_out1", {56'd0, out}, 64'h22);
    chk("bp_rel_valid1", {63'd0, out_valid}, 64'd1);
    step();
    chk("bp_rel_out2", {56'd0, out}, 64'h33);
    chk("bp_rel_valid2", {63'd0, out_valid}, 64'd1);
    step();
    chk("bp_rel_empty", {63'd0, out_valid}, 64'd0);
    chk("bp_count", {48'd0, op_count}, 64'd12);

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h44;
    step();
    a = 8'h55;
    step();
    chk("fl_count", {48'd0, op_count}, 64'd14);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("fl_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_rst_count", {48'd0, op_count}, 64'd0);
    chk("fl_rst_out", {56'd0, out}, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_no_stale", {63'd0, out_valid}, 64'd0);
    end

`ifdef LOGICOP_PIPE_REDUCE_EN
    // Reduction outputs
    a = 8'hFF; b = 8'hFF; op = 3'd0; in_valid = 1'b1;
    step();
    op = 3'd2;
    step();
    in_valid = 1'b0;
    chk("red_and_out", {56'd0, out}, 64'hFF);
    chk("red_and_ones", {63'd0, out_ones}, 64'd1);
    chk("red_and_par", {63'd0, out_parity}, 64'd0);
    step();
    chk("red_xor_out", {56'd0, out}, 64'h00);
    chk("red_xor_ones", {63'd0, out_ones}, 64'd0);
    chk("red_xor_par", {63'd0, out_parity}, 64'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    // Counter saturation
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h5A; b = 8'hA5; op = 3'd2;
    for (int k = 0; k < 65534; k++) begin
      step();
    end
    chk("sat_fffe", {48'd0, op_count}, 64'hFFFE);
    step();
    chk("sat_ffff_1", {48'd0, op_count}, 64'hFFFF);
    step();
    step();
    chk("sat_ffff_3", {48'd0, op_count}, 64'hFFFF);
    in_valid = 1'b0;
    step();
    chk("sat_out", {56'd0, out}, 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
